spi_led_tx: RTL
===============

Name: spi_led_tx

Overview:
SPI-style master transmitter that shifts an 8-bit value (normally the up/down counter's val) into an external LED shift-register/latch (74HC595-type). It produces SCLK, MOSI and a chip-select/latch strobe, and offers a start/busy/done handshake to the control logic. This is the output end of the LED datapath; the counter is the value source.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period (minimum 1)
DATA_W, 8, bits per frame
MSB_FIRST, 1, 1 = send bit DATA_W-1 first; 0 = send bit 0 first

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high; returns the block to IDLE
start  in  1  request a frame; sampled only in IDLE
data  in  DATA_W  value to send; captured on the accepting edge
busy  out  1  high while a frame is in progress
done  out  1  one-cycle pulse when the frame completes
sclk  out  1  serial clock, idles low (mode 0)
mosi  out  1  serial data, stable around each SCLK rising edge
cs_n  out  1  active-low select; its rising edge latches the LED register

Behaviour:
- Reset (async, any state): sclk=0, mosi=0, cs_n=1, busy=0, done=0, shift register=0, counters=0, state=IDLE.
- States: IDLE, SETUP, SHIFT, HOLD.
- IDLE: if start=1, data goes into the shift register on that edge; busy=1, cs_n=0, mosi=first bit, enter SETUP. If start=0, stay in IDLE.
- SETUP: sclk low for CLK_DIV cycles, then enter SHIFT.
- SHIFT: each bit takes a high phase of CLK_DIV cycles followed by a low phase of CLK_DIV cycles.
  - sclk rises at the start of each high phase. The receiver samples on this edge.
  - On the edge where sclk falls, mosi moves to the next bit.
  - After the DATA_W-th high phase, sclk falls, mosi=0, and the block enters HOLD.
  - Exactly DATA_W rising edges per frame.
- HOLD: sclk low for CLK_DIV cycles. On the exit edge: cs_n=1, busy=0, done=1 for exactly one cycle, state=IDLE.
- busy is high for CLK_DIV*(2*DATA_W+2) cycles. Defaults give 72 cycles.
- Bit order is set by MSB_FIRST. The shift register shifts once per falling edge.
- Ignored while busy: start, and any change on data. The frame uses the value captured at acceptance.
- Back-to-back frames: start=1 in the done cycle (state IDLE) is accepted. cs_n then stays high for exactly that one cycle before going low again.
- Reset mid-frame: outputs go idle immediately with no done pulse. The next start begins a clean frame.
- sclk, mosi and cs_n are driven directly from registers, with no combinational outputs.

Test Plan:
- Assert reset, then release -> sclk=0, mosi=0, cs_n=1, busy=0, done=0, with no activity while start=0.
- CLK_DIV=4, start with data=8'hA5 -> on the 8 sclk rising edges mosi reads 1,0,1,0,0,1,0,1; busy high for 72 cycles; cs_n low for the whole frame; a single done pulse in the cycle where cs_n rises.
- During the frame, pulse start and change data to 8'h3C -> no restart, frame still sends A5, exactly 8 sclk edges.
- start=1 held in the done cycle with data=8'hFF -> second frame starts immediately and sends 11111111; cs_n high for exactly 1 cycle between frames; 2 done pulses in total.
- Assert reset after the 3rd sclk rising edge -> outputs idle in the same cycle with no done pulse; then start with 8'h01 -> full correct frame 00000001.
- MSB_FIRST=0, CLK_DIV=1, data=8'h80 -> mosi reads 0,0,0,0,0,0,0,1 and busy lasts 18 cycles. Integration check: counter incremented past 255 saturates at val=255, and sending it gives 11111111.

Source files
------------

// File: rtl/spi_led_tx.sv
// spi_led_tx: SPI-style (mode 0) master transmitter feeding a 74HC595-type
// LED shift register / latch. One frame shifts DATA_W bits out on mosi with
// DATA_W rising edges of sclk. cs_n frames the transfer, and its rising edge
// latches the LED register.
//
// Ports:
//   clk    in   system clock; all logic on the rising edge
//   reset  in   asynchronous, active-high; returns the block to IDLE
//   start  in   frame request, sampled only while idle
//   data   in   [DATA_W-1:0] frame value, captured on the accepting edge
//   busy   out  high while a frame is in progress
//   done   out  one-cycle pulse in the cycle where cs_n returns high
//   sclk   out  serial clock, idles low
//   mosi   out  serial data, changes only while sclk is low
//   cs_n   out  active-low select / latch strobe
//
// Frame timing in clk cycles (C = CLK_DIV):
//   SETUP C low | DATA_W x (C high + C low) | HOLD C low
// busy is therefore high for C*(2*DATA_W+2) cycles.
module spi_led_tx #(
    parameter int CLK_DIV   = 4,
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     div_q, div_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tick;
    logic              last_bit;

    // Bit that goes on the wire next, given the current shift-register contents.
    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? v[DATA_W-1] : v[0];
    endfunction

    // Move the next bit into the position first_bit() reads from.
    function automatic logic [DATA_W-1:0] shift_once(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
    endfunction

    // tick marks the last clk cycle of the current SCLK half-period.
    assign tick     = (div_q == DIV_LAST);
    assign last_bit = (bit_q == BIT_LAST);

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
        end
    end

    // Output and shift registers; every pin comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q   <= '0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            cs_n_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
            cs_n_q <= cs_n_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + 1'b1;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (start) state_d = SETUP;
            end
            SETUP: begin
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                // A bit ends at the close of its low phase.
                if (tick && !sclk_q) begin
                    if (last_bit) begin
                        state_d = HOLD;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the output and shift registers.
    always_comb begin
        sh_d   = sh_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        cs_n_d = cs_n_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d   = data;
                    mosi_d = first_bit(data);
                    cs_n_d = 1'b0;
                    busy_d = 1'b1;
                end
            end
            SETUP: begin
                if (tick) sclk_d = 1'b1;
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        // Falling edge: present the next bit (or park mosi low
                        // after the final bit) while sclk is low.
                        sclk_d = 1'b0;
                        sh_d   = shift_once(sh_q);
                        mosi_d = last_bit ? 1'b0 : first_bit(shift_once(sh_q));
                    end else if (!last_bit) begin
                        sclk_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_d = 1'b1;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign cs_n = cs_n_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
